oldland_mem_arbiter: RTL and testbench

OLDLAND_MEM_ARBITER -- requirements
Module: oldland_mem_arbiter

---
 rtl/oldland_bus_defs.sv | 32 +++
 rtl/oldland_mem_arbiter_if.sv | 52 +++++
 rtl/oldland_bus_timeout.sv | 40 ++++
 rtl/oldland_mem_arbiter.sv | 119 +++++++++++
 tb/tb_oldland_mem_arbiter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/oldland_bus_defs.sv
// Shared definitions for the oldland memory arbiter: widths, states, defaults.
package oldland_bus_defs;

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BSEL_W = 4;
  localparam int unsigned TMO_W  = 16;

  localparam logic [TMO_W-1:0] TIMEOUT_CYCLES_DEFAULT = 16'd1024;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_e;

  // Requester most recently granted, used for round-robin on contention
  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

  // Request fields driven onto the shared bus
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BSEL_W-1:0] bytesel;
    logic              wr_en;
    logic [DATA_W-1:0] wr_val;
  } bus_req_t;

endpackage

// File: rtl/oldland_mem_arbiter_if.sv
// Bundle of instruction, data and shared memory bus signals around the arbiter.
interface oldland_mem_arbiter_if;
  import oldland_bus_defs::*;

  // instruction requester
  logic              i_access;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_data;
  logic              i_ack;
  logic              i_error;

  // data requester
  logic              d_access;
  logic [ADDR_W-1:0] d_addr;
  logic [BSEL_W-1:0] d_bytesel;
  logic              d_wr_en;
  logic [DATA_W-1:0] d_wr_val;
  logic [DATA_W-1:0] d_data;
  logic              d_ack;
  logic              d_error;

  // shared memory bus
  logic              m_access;
  logic [ADDR_W-1:0] m_addr;
  logic [BSEL_W-1:0] m_bytesel;
  logic              m_wr_en;
  logic [DATA_W-1:0] m_wr_val;
  logic [DATA_W-1:0] m_data;
  logic              m_ack;
  logic              m_error;

  // Arbiter side: master of the shared bus, responder to both requesters
  modport master (
    input  i_access, i_addr,
    output i_data, i_ack, i_error,
    input  d_access, d_addr, d_bytesel, d_wr_en, d_wr_val,
    output d_data, d_ack, d_error,
    output m_access, m_addr, m_bytesel, m_wr_en, m_wr_val,
    input  m_data, m_ack, m_error
  );

  // Environment side: requesters plus the memory slave
  modport slave (
    output i_access, i_addr,
    input  i_data, i_ack, i_error,
    output d_access, d_addr, d_bytesel, d_wr_en, d_wr_val,
    input  d_data, d_ack, d_error,
    input  m_access, m_addr, m_bytesel, m_wr_en, m_wr_val,
    output m_data, m_ack, m_error
  );

endinterface

// File: rtl/oldland_bus_timeout.sv
// Grant timeout counter: expired is high while the count equals TIMEOUT_CYCLES-1.
module oldland_bus_timeout
  import oldland_bus_defs::*;
#(
  parameter logic [TMO_W-1:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TMO_W-1:0] LIMIT = TIMEOUT_CYCLES - TMO_W'(1);

  logic [TMO_W-1:0] count;
  logic [TMO_W-1:0] count_nxt;

  // Next count: clear wins over enable
  always_comb begin
    count_nxt = count;
    if (clear) begin
      count_nxt = '0;
    end else if (enable) begin
      count_nxt = count + TMO_W'(1);
    end
  end

  // Count register with expiry flag registered alongside it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count   <= '0;
      expired <= (LIMIT == '0);
    end else begin
      count   <= count_nxt;
      expired <= (count_nxt == LIMIT);
    end
  end

endmodule

// File: rtl/oldland_mem_arbiter.sv
// Round-robin arbiter sharing one memory bus between I$ refill and data port.
module oldland_mem_arbiter
  import oldland_bus_defs::*;
#(
  parameter logic [TMO_W-1:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  oldland_mem_arbiter_if.master bus
);

  arb_state_e state;
  arb_state_e state_nxt;
  grant_e     last_grant;
  grant_e     last_grant_nxt;

  logic     in_grant;
  logic     tmo_expired;
  logic     tmo_enable;
  logic     tmo_err;
  logic     done;
  bus_req_t req;

  assign in_grant   = (state != IDLE);
  assign tmo_enable = in_grant & ~bus.m_ack & ~bus.m_error;
  // An ack in the expiry cycle completes normally instead of timing out
  assign tmo_err    = in_grant & tmo_expired & ~bus.m_ack;
  assign done       = bus.m_ack | bus.m_error | tmo_expired;

  // Timer is held clear in IDLE so every grant starts from zero
  oldland_bus_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (~in_grant),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  // State and round-robin history registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= GNT_I;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Next-state selection and combinational forwarding to/from the granted requester
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    req            = '0;
    bus.m_access   = 1'b0;
    bus.i_data     = '0;
    bus.i_ack      = 1'b0;
    bus.i_error    = 1'b0;
    bus.d_data     = '0;
    bus.d_ack      = 1'b0;
    bus.d_error    = 1'b0;

    case (state)
      IDLE: begin
        if (bus.i_access && bus.d_access) begin
          state_nxt = (last_grant == GNT_I) ? GRANT_D : GRANT_I;
        end else if (bus.d_access) begin
          state_nxt = GRANT_D;
        end else if (bus.i_access) begin
          state_nxt = GRANT_I;
        end
      end
      GRANT_I: begin
        if (done) begin
          state_nxt      = IDLE;
          last_grant_nxt = GNT_I;
        end
      end
      GRANT_D: begin
        if (done) begin
          state_nxt      = IDLE;
          last_grant_nxt = GNT_D;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Outputs stay quiet while reset is asserted, even if a grant is in flight
    if (rst_n) begin
      if (state == GRANT_I) begin
        bus.m_access = 1'b1;
        req.addr     = bus.i_addr;
        req.bytesel  = '1;
        req.wr_en    = 1'b0;
        req.wr_val   = '0;
        bus.i_data   = bus.m_data;
        bus.i_ack    = bus.m_ack;
        bus.i_error  = bus.m_error | tmo_err;
      end else if (state == GRANT_D) begin
        bus.m_access = 1'b1;
        req.addr     = bus.d_addr;
        req.bytesel  = bus.d_bytesel;
        req.wr_en    = bus.d_wr_en;
        req.wr_val   = bus.d_wr_val;
        bus.d_data   = bus.m_data;
        bus.d_ack    = bus.m_ack;
        bus.d_error  = bus.m_error | tmo_err;
      end
    end

    bus.m_addr    = req.addr;
    bus.m_bytesel = req.bytesel;
    bus.m_wr_en   = req.wr_en;
    bus.m_wr_val  = req.wr_val;
  end

endmodule

// File: tb/tb_oldland_mem_arbiter.sv
// Directed self-checking bench for oldland_mem_arbiter (timeout set to 8 cycles).
module tb_oldland_mem_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  oldland_mem_arbiter_if bus ();

  oldland_mem_arbiter #(
    .TIMEOUT_CYCLES (16'd8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports mismatches
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_access  = 1'b0;
    bus.i_addr    = '0;
    bus.d_access  = 1'b0;
    bus.d_addr    = '0;
    bus.d_bytesel = '0;
    bus.d_wr_en   = 1'b0;
    bus.d_wr_val  = '0;
    bus.m_data    = '0;
    bus.m_ack     = 1'b0;
    bus.m_error   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    settle();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;

    // Reset state
    do_reset();
    check("rst_m_access", 32'(bus.m_access), 32'd0);
    check("rst_i_ack",    32'(bus.i_ack),    32'd0);
    check("rst_d_ack",    32'(bus.d_ack),    32'd0);
    check("rst_i_error",  32'(bus.i_error),  32'd0);
    check("rst_d_error",  32'(bus.d_error),  32'd0);

    // Data write alone, memory acks two cycles after m_access
    bus.d_access  = 1'b1;
    bus.d_addr    = 30'h100;
    bus.d_wr_en   = 1'b1;
    bus.d_bytesel = 4'h3;
    bus.d_wr_val  = 32'hcafef00d;
    settle();
    check("wr_idle_m_access", 32'(bus.m_access), 32'd0);
    tick();
    check("wr_m_access",  32'(bus.m_access),  32'd1);
    check("wr_m_addr",    32'(bus.m_addr),    32'h100);
    check("wr_m_wr_en",   32'(bus.m_wr_en),   32'd1);
    check("wr_m_bytesel", 32'(bus.m_bytesel), 32'h3);
    check("wr_m_wr_val",  bus.m_wr_val,       32'hcafef00d);
    check("wr_d_ack_early", 32'(bus.d_ack),   32'd0);
    tick();
    check("wr_d_ack_wait", 32'(bus.d_ack), 32'd0);
    tick();
    bus.m_ack = 1'b1;
    settle();
    check("wr_d_ack", 32'(bus.d_ack), 32'd1);
    check("wr_i_ack", 32'(bus.i_ack), 32'd0);
    tick();
    bus.m_ack    = 1'b0;
    bus.d_access = 1'b0;
    settle();
    check("wr_d_ack_pulse", 32'(bus.d_ack),    32'd0);
    check("wr_after_idle",  32'(bus.m_access), 32'd0);

    // Contention after reset: D first, then alternating D/I/D/I
    do_reset();
    bus.i_access = 1'b1;
    bus.i_addr   = 30'h200;
    bus.d_access = 1'b1;
    bus.d_addr   = 30'h300;
    bus.d_wr_en  = 1'b0;
    bus.d_bytesel = 4'hc;
    settle();
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_m_access", 32'(bus.m_access), 32'd1);
      check("rr_m_addr", 32'(bus.m_addr), (k % 2 == 0) ? 32'h300 : 32'h200);
      bus.m_ack  = 1'b1;
      bus.m_data = (k == 1) ? 32'hdeadbeef : 32'h1234_0000 + 32'(k);
      settle();
      if (k % 2 == 0) begin
        check("rr_d_ack", 32'(bus.d_ack), 32'd1);
        check("rr_i_ack", 32'(bus.i_ack), 32'd0);
      end else begin
        check("rr_i_ack",     32'(bus.i_ack),     32'd1);
        check("rr_d_ack",     32'(bus.d_ack),     32'd0);
        check("rd_i_data",    bus.i_data,         (k == 1) ? 32'hdeadbeef : 32'h1234_0003);
        check("rd_m_bytesel", 32'(bus.m_bytesel), 32'hf);
        check("rd_m_wr_en",   32'(bus.m_wr_en),   32'd0);
      end
      tick();
      bus.m_ack = 1'b0;
      settle();
      check("rr_idle_gap", 32'(bus.m_access), 32'd0);
    end
    bus.i_access = 1'b0;
    bus.d_access = 1'b0;

    // Instruction fetch with no response: error on the 8th grant cycle
    bus.i_access = 1'b1;
    settle();
    for (int c = 1; c <= 8; c++) begin
      tick();
      check("tmo_m_access", 32'(bus.m_access), 32'd1);
      check("tmo_i_error",  32'(bus.i_error),  (c == 8) ? 32'd1 : 32'd0);
      check("tmo_i_ack",    32'(bus.i_ack),    32'd0);
    end
    bus.i_access = 1'b0;
    tick();
    check("tmo_release", 32'(bus.m_access), 32'd0);
    check("tmo_err_pulse", 32'(bus.i_error), 32'd0);

    // Ack arriving in the expiry cycle completes without error
    bus.d_access = 1'b1;
    settle();
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 8) bus.m_ack = 1'b1;
      settle();
    end
    check("tmo_ack_d_ack",   32'(bus.d_ack),   32'd1);
    check("tmo_ack_d_error", 32'(bus.d_error), 32'd0);
    tick();
    bus.m_ack    = 1'b0;
    bus.d_access = 1'b0;
    settle();
    check("tmo_ack_idle", 32'(bus.m_access), 32'd0);

    // Reset while D is granted; late ack must be ignored
    bus.d_access = 1'b1;
    bus.d_addr   = 30'h044;
    settle();
    tick();
    check("mid_grant_d", 32'(bus.m_access), 32'd1);
    rst_n = 1'b0;
    settle();
    check("mid_rst_m_access", 32'(bus.m_access), 32'd0);
    tick();
    rst_n        = 1'b1;
    bus.m_ack    = 1'b1;
    bus.i_access = 1'b1;
    bus.i_addr   = 30'h055;
    settle();
    check("late_ack_d_ack",    32'(bus.d_ack),    32'd0);
    check("late_ack_m_access", 32'(bus.m_access), 32'd0);
    tick();
    bus.m_ack = 1'b0;
    settle();
    check("post_rst_prefers_d", 32'(bus.m_addr), 32'h044);

    // Bus error on D, pending I granted next
    bus.m_error = 1'b1;
    settle();
    check("err_d_error", 32'(bus.d_error), 32'd1);
    check("err_d_ack",   32'(bus.d_ack),   32'd0);
    check("err_i_error", 32'(bus.i_error), 32'd0);
    tick();
    bus.m_error  = 1'b0;
    bus.d_access = 1'b0;
    settle();
    check("err_pulse", 32'(bus.d_error), 32'd0);
    check("err_idle",  32'(bus.m_access), 32'd0);
    tick();
    check("err_then_i", 32'(bus.m_addr), 32'h055);
    check("err_then_i_bsel", 32'(bus.m_bytesel), 32'hf);
    bus.m_ack = 1'b1;
    settle();
    check("err_then_i_ack", 32'(bus.i_ack), 32'd1);
    tick();
    bus.m_ack    = 1'b0;
    bus.i_access = 1'b0;
    settle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
